fp_neuron_node: RTL and testbench

- Single-precision (IEEE-754 binary32) neuron pre-activation unit.
- Computes out = (in1*weight1 + in2*weight2) + bias.
- Fully pipelined: accepts one operand set per clock, fixed latency.
- Sits between the input layer / preceding sigmoid stage and the next sigmoid stage of the XOR network datapath.

---
 rtl/fp_neuron_node_if.sv | 21 ++
 rtl/fp_neuron_node.sv | 248 ++++++++++++++++++++++++
 tb/tb_fp_neuron_node.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_neuron_node_if.sv
// Operand/result bundle for the binary32 neuron pre-activation unit.
interface fp_neuron_node_if;
    logic        in_valid;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [31:0] weight1;
    logic [31:0] weight2;
    logic [31:0] bias;
    logic [31:0] out;
    logic        out_valid;

    modport master (
        output in_valid, in1, in2, weight1, weight2, bias,
        input  out, out_valid
    );

    modport slave (
        input  in_valid, in1, in2, weight1, weight2, bias,
        output out, out_valid
    );
endinterface

// File: rtl/fp_neuron_node.sv
// Binary32 neuron pre-activation: out = (in1*weight1 + in2*weight2) + bias.
// Four-cycle latency, one operand set per clock. Subnormals flush to signed
// zero, every operation rounds to nearest-even, NaNs come out canonical.
module fp_neuron_node (
    input  logic            clk,
    input  logic            reset,
    fp_neuron_node_if.slave bus
);
    localparam logic [31:0] QNAN = 32'h7FC00000;

    // Product in flight between the multiply and its normalize/round stage.
    typedef struct packed {
        logic              nan;
        logic              inf;
        logic              zero;
        logic              sign;
        logic signed [9:0] exp;
        logic [47:0]       prod;
    } prod_t;

    // Final packing with overflow to infinity and underflow to signed zero.
    function automatic logic [31:0] pack(input logic s, input logic signed [9:0] e,
                                         input logic [22:0] f);
        logic [31:0] r;
        if (e >= 10'sd255)
            r = {s, 8'hFF, 23'd0};
        else if (e <= 10'sd0)
            r = {s, 31'd0};
        else
            r = {s, e[7:0], f};
        return r;
    endfunction

    function automatic prod_t mul_unpack(input logic [31:0] a, input logic [31:0] b);
        prod_t r;
        logic  a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
        a_max  = &a[30:23];
        b_max  = &b[30:23];
        a_zero = ~|a[30:23];
        b_zero = ~|b[30:23];
        a_nan  = a_max & (|a[22:0]);
        b_nan  = b_max & (|b[22:0]);
        a_inf  = a_max & ~(|a[22:0]);
        b_inf  = b_max & ~(|b[22:0]);
        r.sign = a[31] ^ b[31];
        r.nan  = a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
        r.inf  = a_inf | b_inf;
        r.zero = a_zero | b_zero;
        r.exp  = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        r.prod = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        return r;
    endfunction

    function automatic logic [31:0] mul_round(input prod_t p);
        logic [31:0]       r;
        logic [23:0]       mant;
        logic              g, st;
        logic [24:0]       rnd;
        logic signed [9:0] e;
        if (p.prod[47]) begin
            mant = p.prod[47:24];
            g    = p.prod[23];
            st   = |p.prod[22:0];
            e    = p.exp + 10'sd1;
        end else begin
            mant = p.prod[46:23];
            g    = p.prod[22];
            st   = |p.prod[21:0];
            e    = p.exp;
        end
        rnd = {1'b0, mant} + {24'd0, g & (st | mant[0])};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'sd1;
        end
        if (p.nan)
            r = QNAN;
        else if (p.inf)
            r = {p.sign, 8'hFF, 23'd0};
        else if (p.zero)
            r = {p.sign, 31'd0};
        else
            r = pack(p.sign, e, rnd[22:0]);
        return r;
    endfunction

    // Single rounded add. Bits [2:0] of the 27-bit working mantissa are
    // guard, round and sticky; the sticky bit absorbs everything shifted out.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]       r, big, sml;
        logic              a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
        logic [7:0]        d;
        logic [26:0]       m_big, m_sml, sh, nrm;
        logic              stk;
        logic [27:0]       sum;
        logic [4:0]        msb, lz;
        logic [24:0]       rnd;
        logic signed [9:0] e;
        a_max  = &a[30:23];
        b_max  = &b[30:23];
        a_zero = ~|a[30:23];
        b_zero = ~|b[30:23];
        a_nan  = a_max & (|a[22:0]);
        b_nan  = b_max & (|b[22:0]);
        a_inf  = a_max & ~(|a[22:0]);
        b_inf  = b_max & ~(|b[22:0]);

        // Order by magnitude so the difference below is never negative.
        if (a[30:0] >= b[30:0]) begin
            big = a;
            sml = b;
        end else begin
            big = b;
            sml = a;
        end
        d     = big[30:23] - sml[30:23];
        m_big = {1'b1, big[22:0], 3'b000};
        m_sml = {1'b1, sml[22:0], 3'b000};
        if (d >= 8'd27) begin
            sh  = 27'd0;
            stk = 1'b1;
        end else begin
            sh  = m_sml >> d;
            stk = |(m_sml & ~(27'h7FFFFFF << d));
        end
        sh[0] = sh[0] | stk;
        if (big[31] ^ sml[31])
            sum = {1'b0, m_big} - {1'b0, sh};
        else
            sum = {1'b0, m_big} + {1'b0, sh};

        e   = $signed({2'b00, big[30:23]});
        msb = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum[i]) msb = i[4:0];
        lz  = 5'd26 - msb;
        if (sum[27]) begin
            nrm = sum[27:1] | {26'd0, sum[0]};
            e   = e + 10'sd1;
        end else begin
            nrm = sum[26:0] << lz;
            e   = e - $signed({5'd0, lz});
        end
        rnd = {1'b0, nrm[26:3]} + {24'd0, nrm[2] & (nrm[1] | nrm[0] | nrm[3])};
        if (rnd[24]) begin
            rnd = rnd >> 1;
            e   = e + 10'sd1;
        end

        if (a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31])))
            r = QNAN;
        else if (a_inf)
            r = {a[31], 8'hFF, 23'd0};
        else if (b_inf)
            r = {b[31], 8'hFF, 23'd0};
        else if (a_zero & b_zero)
            r = {a[31] & b[31], 31'd0};
        else if (a_zero)
            r = b;
        else if (b_zero)
            r = a;
        else if (sum == 28'd0)
            r = 32'd0;
        else
            r = pack(big[31], e, rnd[22:0]);
        return r;
    endfunction

    logic        r0_valid, s1_valid, s2_valid, s3_valid;
    logic [31:0] r0_in1, r0_in2, r0_w1, r0_w2, r0_bias;
    prod_t       s1_p1, s1_p2;
    logic [31:0] s1_bias;
    logic [31:0] s2_p1, s2_p2, s2_bias;
    logic [31:0] s3_sum, s3_bias;

    // Input capture: operands and their valid flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r0_valid <= 1'b0;
            r0_in1   <= '0;
            r0_in2   <= '0;
            r0_w1    <= '0;
            r0_w2    <= '0;
            r0_bias  <= '0;
        end else begin
            r0_valid <= bus.in_valid;
            r0_in1   <= bus.in1;
            r0_in2   <= bus.in2;
            r0_w1    <= bus.weight1;
            r0_w2    <= bus.weight2;
            r0_bias  <= bus.bias;
        end
    end

    // S1: classify operands, mantissa products and exponent sums.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_p1    <= '0;
            s1_p2    <= '0;
            s1_bias  <= '0;
        end else begin
            s1_valid <= r0_valid;
            s1_p1    <= mul_unpack(r0_in1, r0_w1);
            s1_p2    <= mul_unpack(r0_in2, r0_w2);
            s1_bias  <= r0_bias;
        end
    end

    // S2: normalize and round both products.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_p1    <= '0;
            s2_p2    <= '0;
            s2_bias  <= '0;
        end else begin
            s2_valid <= s1_valid;
            s2_p1    <= mul_round(s1_p1);
            s2_p2    <= mul_round(s1_p2);
            s2_bias  <= s1_bias;
        end
    end

    // S3: sum of the two products.
    always_ff @(posedge clk) begin
        if (reset) begin
            s3_valid <= 1'b0;
            s3_sum   <= '0;
            s3_bias  <= '0;
        end else begin
            s3_valid <= s2_valid;
            s3_sum   <= fp_add(s2_p1, s2_p2);
            s3_bias  <= s2_bias;
        end
    end

    // S4: add bias and register the result.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.out_valid <= 1'b0;
            bus.out       <= '0;
        end else begin
            bus.out_valid <= s3_valid;
            bus.out       <= fp_add(s3_sum, s3_bias);
        end
    end
endmodule

// File: tb/tb_fp_neuron_node.sv
// Directed and streamed checks of the binary32 neuron pre-activation unit.
module tb_fp_neuron_node;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_pass   = 0;

    fp_neuron_node_if bus();

    fp_neuron_node dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference conversion between binary32 patterns and reals.
    function automatic real to_real(input logic [31:0] x);
        real m;
        int  e;
        if (x[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(x[22:0]) / 8388608.0;
        e = int'(x[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return x[31] ? -m : m;
    endfunction

    function automatic logic [31:0] to_bits(input real x);
        real         a, sc, fr;
        int          e;
        int unsigned mi;
        logic        s;
        if (x == 0.0) return 32'h0;
        s = (x < 0.0);
        a = s ? -x : x;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        sc = (a - 1.0) * 8388608.0;
        mi = $rtoi(sc);
        fr = sc - real'(mi);
        if (fr > 0.5 || (fr == 0.5 && mi[0])) mi++;
        if (mi == 32'd8388608) begin mi = 0; e++; end
        return {s, e[7:0], mi[22:0]};
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] w1,
                         input logic [31:0] b, input logic [31:0] w2, input logic [31:0] bi);
        bus.in_valid = v;
        bus.in1      = a;
        bus.weight1  = w1;
        bus.in2      = b;
        bus.weight2  = w2;
        bus.bias     = bi;
    endtask

    // One isolated operand set; reports out_valid one edge early and the result edge.
    task automatic send_op(input logic [31:0] a, input logic [31:0] w1, input logic [31:0] b,
                           input logic [31:0] w2, input logic [31:0] bi,
                           output logic early_v, output logic [31:0] o, output logic o_v);
        @(negedge clk);
        drive(1'b1, a, w1, b, w2, bi);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(posedge clk);
        #1 early_v = bus.out_valid;
        @(posedge clk);
        #1 o = bus.out;
        o_v = bus.out_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out !== 32'h0 || bus.out_valid !== 1'b0)
            $display("FAIL reset_first_edge: out=%h valid=%b, expected out=00000000 valid=0",
                     bus.out, bus.out_valid);
        else n_pass++;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.out_valid !== 1'b0)
                $display("FAIL reset_idle[%0d]: valid=%b, expected 0", c, bus.out_valid);
            else n_pass++;
        end
    endtask

    task automatic test_h1();
        logic [31:0] vin1 [3];
        logic [31:0] vin2 [3];
        logic [31:0] vexp [3];
        logic        ev, ov;
        logic [31:0] o;
        vin1 = '{32'h00000000, 32'h3F800000, 32'h3F800000};
        vin2 = '{32'h00000000, 32'h00000000, 32'h3F800000};
        vexp = '{32'hC1200000, 32'h41200000, 32'h41F00000};
        for (int i = 0; i < 3; i++) begin
            send_op(vin1[i], 32'h41A00000, vin2[i], 32'h41A00000, 32'hC1200000, ev, o, ov);
            n_checks++;
            if (o !== vexp[i] || ov !== 1'b1 || ev !== 1'b0)
                $display("FAIL h1[%0d]: out=%h valid=%b early_valid=%b, expected out=%h valid=1 early_valid=0",
                         i, o, ov, ev, vexp[i]);
            else n_pass++;
        end
    endtask

    task automatic test_h2();
        logic [31:0] vin [2];
        logic [31:0] vexp [2];
        logic        ev, ov;
        logic [31:0] o;
        vin  = '{32'h3F800000, 32'h00000000};
        vexp = '{32'hC1200000, 32'h41F00000};
        for (int i = 0; i < 2; i++) begin
            send_op(vin[i], 32'hC1A00000, vin[i], 32'hC1A00000, 32'h41F00000, ev, o, ov);
            n_checks++;
            if (o !== vexp[i] || ov !== 1'b1 || ev !== 1'b0)
                $display("FAIL h2[%0d]: out=%h valid=%b early_valid=%b, expected out=%h valid=1 early_valid=0",
                         i, o, ov, ev, vexp[i]);
            else n_pass++;
        end
    endtask

    // Columns: in1, weight1, in2, weight2, bias, expected out.
    task automatic test_rounding();
        logic [31:0] t [7][6];
        logic        ev, ov;
        logic [31:0] o;
        t[0] = '{32'h3F800000, 32'h3F800000, 32'h33800000, 32'h3F800000, 32'h0, 32'h3F800000};
        t[1] = '{32'h3F800001, 32'h3F800000, 32'h33800000, 32'h3F800000, 32'h0, 32'h3F800002};
        t[2] = '{32'h3F800000, 32'h3F800000, 32'hB3000000, 32'h3F800000, 32'h0, 32'h3F800000};
        t[3] = '{32'h3F800000, 32'h3F800000, 32'hB3800000, 32'h3F800000, 32'h0, 32'h3F7FFFFF};
        t[4] = '{32'h3F800001, 32'h3F800001, 32'h0, 32'h0, 32'h0, 32'h3F800002};
        t[5] = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h0, 32'h00000000};
        t[6] = '{32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 32'hBF800000, 32'h00000000};
        for (int i = 0; i < 7; i++) begin
            send_op(t[i][0], t[i][1], t[i][2], t[i][3], t[i][4], ev, o, ov);
            n_checks++;
            if (o !== t[i][5] || ov !== 1'b1)
                $display("FAIL rounding[%0d]: out=%h valid=%b, expected out=%h valid=1",
                         i, o, ov, t[i][5]);
            else n_pass++;
        end
    endtask

    task automatic test_specials();
        logic [31:0] t [8][6];
        logic        ev, ov;
        logic [31:0] o;
        t[0] = '{32'h7F800000, 32'h00000000, 32'h0, 32'h0, 32'h0, 32'h7FC00000};
        t[1] = '{32'h7F000000, 32'h7F000000, 32'h0, 32'h0, 32'h0, 32'h7F800000};
        t[2] = '{32'h00000001, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h00000000};
        t[3] = '{32'h7F800001, 32'h3F800000, 32'h0, 32'h0, 32'h0, 32'h7FC00000};
        t[4] = '{32'h7F800000, 32'h3F800000, 32'h7F800000, 32'hBF800000, 32'h0, 32'h7FC00000};
        t[5] = '{32'h80000000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h80000000, 32'h80000000};
        t[6] = '{32'hFF000000, 32'h7F000000, 32'h0, 32'h0, 32'h0, 32'hFF800000};
        t[7] = '{32'h7F800000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'hC1200000, 32'h7F800000};
        for (int i = 0; i < 8; i++) begin
            send_op(t[i][0], t[i][1], t[i][2], t[i][3], t[i][4], ev, o, ov);
            n_checks++;
            if (o !== t[i][5] || ov !== 1'b1)
                $display("FAIL specials[%0d]: out=%h valid=%b, expected out=%h valid=1",
                         i, o, ov, t[i][5]);
            else n_pass++;
        end
    endtask

    // Eight sets on consecutive edges; results must follow one per edge, four edges later.
    task automatic test_back_to_back();
        logic [31:0] a [8];
        logic [31:0] w1 [8];
        logic [31:0] b [8];
        logic [31:0] w2 [8];
        logic [31:0] bi [8];
        logic [31:0] ex [8];
        for (int i = 0; i < 8; i++) begin
            a[i]  = to_bits(real'(int'($urandom_range(16)) - 8) / 4.0);
            b[i]  = to_bits(real'(int'($urandom_range(16)) - 8) / 4.0);
            w1[i] = to_bits(real'(int'($urandom_range(40)) - 20));
            w2[i] = to_bits(real'(int'($urandom_range(40)) - 20));
            bi[i] = to_bits(real'(int'($urandom_range(40)) - 20));
            ex[i] = to_bits(to_real(a[i]) * to_real(w1[i]) + to_real(b[i]) * to_real(w2[i])
                            + to_real(bi[i]));
        end
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            if (c < 8) drive(1'b1, a[c], w1[c], b[c], w2[c], bi[c]);
            else       drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
            @(posedge clk);
            #1;
            n_checks++;
            if (c >= 4 && c < 12) begin
                if (bus.out !== ex[c-4] || bus.out_valid !== 1'b1)
                    $display("FAIL stream[%0d]: out=%h valid=%b, expected out=%h valid=1",
                             c - 4, bus.out, bus.out_valid, ex[c-4]);
                else n_pass++;
            end else begin
                if (bus.out_valid !== 1'b0)
                    $display("FAIL stream_idle[edge %0d]: valid=%b, expected 0", c, bus.out_valid);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_inflight();
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c < 4) drive(1'b1, 32'h3F800000, 32'h40000000, 32'h3F800000, 32'h3F800000, 32'h0);
            else       drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (bus.out !== 32'h40400000 || bus.out_valid !== 1'b1)
            $display("FAIL pre_reset: out=%h valid=%b, expected out=40400000 valid=1",
                     bus.out, bus.out_valid);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.out !== 32'h0 || bus.out_valid !== 1'b0)
            $display("FAIL reset_flush: out=%h valid=%b, expected out=00000000 valid=0",
                     bus.out, bus.out_valid);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (bus.out !== 32'h0 || bus.out_valid !== 1'b0)
                $display("FAIL post_reset[%0d]: out=%h valid=%b, expected out=00000000 valid=0",
                         c, bus.out, bus.out_valid);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t, expected completion before 200000", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_h1();
        test_h2();
        test_rounding();
        test_specials();
        test_back_to_back();
        test_reset_inflight();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
